// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 serial transmitter with a small byte FIFO.
// The data register enqueues bytes; the control register exposes status and
// the interrupt enable. INTR requests service whenever the FIFO has room.
module uart_tx_dev #(
    parameter int unsigned             ABITS  = 16,
    parameter int unsigned             DBITS  = 16,
    parameter logic [ABITS-1:0]        DADDR  = ABITS'(16'hFFE8),
    parameter logic [ABITS-1:0]        CADDR  = ABITS'(16'hFFEA),
    parameter int unsigned             CLKDIV = 434,
    parameter int unsigned             DIVB   = 9,
    parameter int unsigned             FABITS = 2
) (
    input  logic             CLK,
    input  logic             INIT_N,
    input  logic [ABITS-1:0] ABUS,
    inout  wire  [DBITS-1:0] RBUS,
    input  logic             RE,
    input  logic [DBITS-1:0] WBUS,
    input  logic             WE,
    input  logic             LOCK,
    output logic             INTR,
    output logic             TXD
);

    localparam int unsigned DEPTH = 1 << FABITS;
    localparam int unsigned CNTW  = FABITS + 1;

    localparam logic [DIVB-1:0] BAUD_LOAD = DIVB'(CLKDIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO storage and pointers
    logic [7:0]        fifo_mem [DEPTH];
    logic [FABITS-1:0] wr_ptr;
    logic [FABITS-1:0] rd_ptr;
    logic [CNTW-1:0]   count;

    // Transmit engine state
    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [DIVB-1:0] baud_cnt;
    logic [DIVB-1:0] baud_nxt;
    logic [7:0]      shifter;
    logic [7:0]      shift_nxt;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_nxt;
    logic            txd_nxt;

    // Register file
    logic       ie;
    logic       ovf;
    logic [7:0] last_byte;

    // Combinational helpers
    logic            full_c;
    logic            empty_c;
    logic            bit_end_c;
    logic            pop_c;
    logic            push_c;
    logic            dwr_c;
    logic            cwr_c;
    logic            ovf_set_c;
    logic            ie_nxt_c;
    logic            ovf_nxt_c;
    logic [CNTW-1:0] count_nxt_c;
    logic            ready_c;
    logic            idle_c;
    logic            rd_hit_c;
    logic [DBITS-1:0] rdata_c;
    logic            unused_c;

    assign full_c    = (count == CNTW'(DEPTH));
    assign empty_c   = (count == '0);
    assign bit_end_c = (baud_cnt == '0);
    assign ready_c   = ~full_c;
    assign idle_c    = empty_c && (state == S_IDLE);

    // Upper write-data bits carry no meaning for this device
    assign unused_c = &{1'b0, WBUS[DBITS-1:8]};

    // Bus write decode; nothing is written while the PLL is unlocked
    always_comb begin
        dwr_c = WE && LOCK && (ABUS == DADDR);
        cwr_c = WE && LOCK && (ABUS == CADDR);
    end

    // Push accepted when there is room, or when a pop frees a slot on the same edge
    always_comb begin
        push_c    = dwr_c && (!full_c || pop_c);
        ovf_set_c = dwr_c && full_c && !pop_c;
    end

    // Next occupancy, interrupt enable and overflow flag
    always_comb begin
        count_nxt_c = count;
        case ({push_c, pop_c})
            2'b10:   count_nxt_c = count + CNTW'(1);
            2'b01:   count_nxt_c = count - CNTW'(1);
            default: count_nxt_c = count;
        endcase

        ie_nxt_c = ie;
        if (cwr_c) begin
            ie_nxt_c = WBUS[4];
        end

        ovf_nxt_c = ovf;
        if (ovf_set_c) begin
            ovf_nxt_c = 1'b1;
        end else if (cwr_c && !WBUS[2]) begin
            ovf_nxt_c = 1'b0;
        end
    end

    // Transmit FSM next-state, baud timing, shifter and serial output
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        shift_nxt = shifter;
        bit_nxt   = bit_idx;
        pop_c     = 1'b0;

        if (LOCK) begin
            case (state)
                S_IDLE: begin
                    if (!empty_c) begin
                        pop_c     = 1'b1;
                        shift_nxt = fifo_mem[rd_ptr];
                        baud_nxt  = BAUD_LOAD;
                        state_nxt = S_START;
                    end
                end
                S_START: begin
                    if (bit_end_c) begin
                        bit_nxt   = 3'd0;
                        baud_nxt  = BAUD_LOAD;
                        state_nxt = S_DATA;
                    end else begin
                        baud_nxt = baud_cnt - DIVB'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        shift_nxt = {1'b0, shifter[7:1]};
                        bit_nxt   = bit_idx + 3'd1;
                        baud_nxt  = BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
                            state_nxt = S_STOP;
                        end
                    end else begin
                        baud_nxt = baud_cnt - DIVB'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end_c) begin
                        if (!empty_c) begin
                            // Back-to-back frame: next start bit follows with no idle gap
                            pop_c     = 1'b1;
                            shift_nxt = fifo_mem[rd_ptr];
                            baud_nxt  = BAUD_LOAD;
                            state_nxt = S_START;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        baud_nxt = baud_cnt - DIVB'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    baud_nxt  = '0;
                end
            endcase
        end

        txd_nxt = 1'b1;
        if (state_nxt == S_START) begin
            txd_nxt = 1'b0;
        end else if (state_nxt == S_DATA) begin
            txd_nxt = shift_nxt[0];
        end else if (LOCK == 1'b0) begin
            txd_nxt = TXD;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transmit datapath registers
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            baud_cnt <= '0;
            shifter  <= '0;
            bit_idx  <= '0;
            TXD      <= 1'b1;
        end else begin
            baud_cnt <= baud_nxt;
            shifter  <= shift_nxt;
            bit_idx  <= bit_nxt;
            TXD      <= txd_nxt;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                fifo_mem[wr_ptr] <= WBUS[7:0];
                wr_ptr           <= wr_ptr + FABITS'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + FABITS'(1);
            end
            count <= count_nxt_c;
        end
    end

    // Control/status registers and interrupt request
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            ie        <= 1'b0;
            ovf       <= 1'b0;
            last_byte <= 8'h00;
            INTR      <= 1'b0;
        end else begin
            ie   <= ie_nxt_c;
            ovf  <= ovf_nxt_c;
            INTR <= ie_nxt_c && (count_nxt_c != CNTW'(DEPTH));
            if (push_c) begin
                last_byte <= WBUS[7:0];
            end
        end
    end

    // Combinational read decode; the bus floats unless this device is addressed
    always_comb begin
        rd_hit_c = 1'b0;
        rdata_c  = '0;
        if (ABUS == DADDR) begin
            rd_hit_c = 1'b1;
            rdata_c  = DBITS'(last_byte);
        end else if (ABUS == CADDR) begin
            rd_hit_c = 1'b1;
            rdata_c  = DBITS'({ie, 1'b0, ovf, idle_c, ready_c});
        end
    end

    assign RBUS = (RE && rd_hit_c) ? rdata_c : {DBITS{1'bz}};

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed checks of the UART transmitter with CLKDIV=4.
module tb_uart_tx_dev;

    localparam logic [15:0] DADDR = 16'hFFE8;
    localparam logic [15:0] CADDR = 16'hFFEA;

    logic        clk;
    logic        init_n;
    logic [15:0] abus;
    tri1  [15:0] rbus;
    logic        re;
    logic [15:0] wbus;
    logic        we;
    logic        lock;
    logic        intr;
    logic        txd;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_dev #(
        .CLKDIV (4)
    ) dut (
        .CLK    (clk),
        .INIT_N (init_n),
        .ABUS   (abus),
        .RBUS   (rbus),
        .RE     (re),
        .WBUS   (wbus),
        .WE     (we),
        .LOCK   (lock),
        .INTR   (intr),
        .TXD    (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-time guard so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        abus = a;
        wbus = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        abus = a;
        re   = 1'b1;
        #1;
        d    = rbus;
        re   = 1'b0;
    endtask

    // Checks one 40-cycle frame from index k0; leaves time just after the frame's last cycle
    task automatic check_frame(input logic [7:0] b, input int k0, input string tag);
        logic exp;
        for (int k = k0; k < 40; k++) begin
            if (k < 4)       exp = 1'b0;
            else if (k >= 36) exp = 1'b1;
            else             exp = b[(k - 4) / 4];
            check_val(tag, 32'(txd), 32'(exp));
            tick();
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic        bad;

        init_n = 1'b0;
        abus   = 16'h0000;
        re     = 1'b0;
        wbus   = 16'h0000;
        we     = 1'b0;
        lock   = 1'b1;

        // T1 reset state and bus float
        #12;
        check_val("t1_txd", 32'(txd), 32'h1);
        check_val("t1_intr", 32'(intr), 32'h0);
        bus_read(CADDR, rd);
        check_val("t1_ctrl", 32'(rd), 32'h0003);
        bus_read(DADDR, rd);
        check_val("t1_data", 32'(rd), 32'h0000);
        abus = 16'h0000; re = 1'b1; #1;
        check_val("t1_float_addr", 32'(rbus), 32'hFFFF);
        abus = CADDR; re = 1'b0; #1;
        check_val("t1_float_re", 32'(rbus), 32'hFFFF);
        @(posedge clk); #1;
        init_n = 1'b1;
        tick();

        // T2 single byte frame
        bus_write(DADDR, 16'h00A5);
        check_val("t2_txd_pre", 32'(txd), 32'h1);
        tick();
        check_frame(8'hA5, 0, "t2_frame");
        bus_read(CADDR, rd);
        check_val("t2_ctrl_idle", 32'(rd), 32'h0003);
        bus_read(DADDR, rd);
        check_val("t2_last", 32'(rd), 32'h00A5);

        // T3 overflow with back-to-back frames
        for (int i = 1; i <= 6; i++) begin
            bus_write(DADDR, 16'(i));
            if (i >= 2 && i <= 5) check_val("t3_start", 32'(txd), 32'h0);
        end
        bus_read(CADDR, rd);
        check_val("t3_ctrl_full", 32'(rd), 32'h0004);
        check_frame(8'h01, 4, "t3_frame01");
        check_frame(8'h02, 0, "t3_frame02");
        check_frame(8'h03, 0, "t3_frame03");
        check_frame(8'h04, 0, "t3_frame04");
        check_frame(8'h05, 0, "t3_frame05");
        bus_read(CADDR, rd);
        check_val("t3_ctrl_ovf", 32'(rd), 32'h0007);
        bus_read(DADDR, rd);
        check_val("t3_last", 32'(rd), 32'h0005);
        bus_write(CADDR, 16'h0000);
        bus_read(CADDR, rd);
        check_val("t3_ovf_clr", 32'(rd), 32'h0003);

        // T4 interrupt tracks IE and FIFO room
        bus_write(CADDR, 16'h0010);
        check_val("t4_intr_en", 32'(intr), 32'h1);
        bus_read(CADDR, rd);
        check_val("t4_ctrl", 32'(rd), 32'h0013);
        for (int i = 0; i < 5; i++) begin
            bus_write(DADDR, 16'(8'h11 + i));
        end
        check_val("t4_intr_full", 32'(intr), 32'h0);
        bus_read(CADDR, rd);
        check_val("t4_ctrl_full", 32'(rd), 32'h0010);
        bad = 1'b0;
        for (int k = 3; k < 40; k++) begin
            if (intr !== 1'b0) bad = 1'b1;
            tick();
        end
        check_val("t4_intr_hold", 32'(bad), 32'h0);
        check_val("t4_intr_pop", 32'(intr), 32'h1);

        // T5 push on the pop edge while full
        bus_write(DADDR, 16'h0016);
        check_val("t5_intr_full", 32'(intr), 32'h0);
        repeat (38) tick();
        check_val("t5_txd_stop", 32'(txd), 32'h1);
        bus_write(DADDR, 16'h0017);
        bus_read(CADDR, rd);
        check_val("t5_ctrl", 32'(rd), 32'h0010);
        bus_read(DADDR, rd);
        check_val("t5_last", 32'(rd), 32'h0017);
        check_val("t5_txd_start", 32'(txd), 32'h0);
        check_val("t5_intr", 32'(intr), 32'h0);

        // T6 reset during data bit 3 of byte 8'h13
        repeat (17) tick();
        check_val("t6_bit3", 32'(txd), 32'h0);
        init_n = 1'b0;
        #1;
        check_val("t6_txd_rst", 32'(txd), 32'h1);
        check_val("t6_intr_rst", 32'(intr), 32'h0);
        bus_read(CADDR, rd);
        check_val("t6_ctrl", 32'(rd), 32'h0003);
        tick();
        init_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (txd !== 1'b1) bad = 1'b1;
            tick();
        end
        check_val("t6_no_tx", 32'(bad), 32'h0);
        bus_read(CADDR, rd);
        check_val("t6_ctrl_after", 32'(rd), 32'h0003);

        // T7 writes ignored while the PLL is unlocked
        lock = 1'b0;
        bus_write(DADDR, 16'h0099);
        bus_write(CADDR, 16'h0010);
        bus_read(DADDR, rd);
        check_val("t7_data", 32'(rd), 32'h0000);
        bus_read(CADDR, rd);
        check_val("t7_ctrl", 32'(rd), 32'h0003);
        repeat (3) tick();
        check_val("t7_txd", 32'(txd), 32'h1);
        check_val("t7_intr", 32'(intr), 32'h0);
        lock = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
